// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use stall, branch flush, dmem freeze+timeout.
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned WAIT_W      = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] id_inst,
    input  logic [31:0] ex_inst,
    input  logic [31:0] mem_inst,
    input  logic        ex_br_taken,
    input  logic        dmem_ready,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        ex_mem_we,
    output logic        mem_wb_we,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        mem_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic [6:0] id_op;
    logic [4:0] ex_rd;
    logic       ex_ld, rs1_use, rs2_use, lu, mb;
    logic [WAIT_W-1:0] cnt_inc;

    // {pc, if_id, id_ex, ex_mem, mem_wb} enables and {if_id, id_ex, mem_wb} flushes
    logic [4:0] run_we, we_c;
    logic [2:0] run_fl, fl_c;

    assign id_op   = id_inst[6:0];
    assign ex_rd   = ex_inst[11:7];
    assign ex_ld   = (ex_inst[6:0] == OP_LOAD) && (ex_rd != 5'd0);
    assign rs1_use = !((id_op == OP_LUI) || (id_op == OP_AUIPC) ||
                       (id_op == OP_JAL));
    assign rs2_use = (id_op == OP_REG) || (id_op == OP_STORE) ||
                     (id_op == OP_BR);
    assign lu = ex_ld &&
                ((rs1_use && (id_inst[19:15] == ex_rd)) ||
                 (rs2_use && (id_inst[24:20] == ex_rd)));
    assign mb = ((mem_inst[6:0] == OP_LOAD) ||
                 (mem_inst[6:0] == OP_STORE)) && !dmem_ready;
    assign cnt_inc = wait_cnt_q + 1'b1;

    always_comb begin
        run_we = 5'b11111;
        run_fl = 3'b000;
        priority case (1'b1)
            mb: begin
                run_we = 5'b00000;
                run_fl = 3'b001;
            end
            ex_br_taken: run_fl = 3'b110;
            lu: begin
                run_we = 5'b00111;
                run_fl = 3'b010;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        we_c       = run_we;
        fl_c       = run_fl;
        unique case (state_q)
            RUN: begin
                if (mb) begin
                    wait_cnt_d = WAIT_W'(1);
                    if (MEM_TIMEOUT <= 1) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    we_c       = 5'b00000;
                    fl_c       = 3'b001;
                    wait_cnt_d = cnt_inc;
                    // this cycle is the MEM_TIMEOUT-th frozen one
                    if (cnt_inc >= TMO) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end
                end
            end
            ERR: begin
                we_c = 5'b00000;
                fl_c = 3'b000;
            end
            default: begin
                state_d = RUN;
                we_c    = 5'b00000;
                fl_c    = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign pc_we        = rstn & we_c[4];
    assign if_id_we     = rstn & we_c[3];
    assign id_ex_we     = rstn & we_c[2];
    assign ex_mem_we    = rstn & we_c[1];
    assign mem_wb_we    = rstn & we_c[0];
    assign if_id_flush  = rstn & fl_c[2];
    assign id_ex_flush  = rstn & fl_c[1];
    assign mem_wb_flush = rstn & fl_c[0];
    assign mem_err      = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_we && state_q != ERR) stall_q <= stall_q + 32'd1;
            if (if_id_flush) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT = 4).
// Counter checks are compiled only when HAZ_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] LW5   = 32'h0000_A283;
    localparam logic [31:0] LW0   = 32'h0000_A003;
    localparam logic [31:0] ADD1  = 32'h0022_8333;
    localparam logic [31:0] ADD2  = 32'h0051_0333;
    localparam logic [31:0] ADDI1 = 32'h0012_8313;
    localparam logic [31:0] ADDI5 = 32'h0051_0313;
    localparam logic [31:0] LUI   = 32'h0002_8337;

    // {pc,ifid,idex,exmem,memwb we, ifid,idex,memwb flush}
    localparam logic [7:0] O_ALL = 8'b11111_000;
    localparam logic [7:0] O_LU  = 8'b00111_010;
    localparam logic [7:0] O_BR  = 8'b11111_110;
    localparam logic [7:0] O_FRZ = 8'b00000_001;
    localparam logic [7:0] O_OFF = 8'b00000_000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] id_inst, ex_inst, mem_inst;
    logic        ex_br_taken, dmem_ready;
    logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .WAIT_W(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .id_inst      (id_inst),
        .ex_inst      (ex_inst),
        .mem_inst     (mem_inst),
        .ex_br_taken  (ex_br_taken),
        .dmem_ready   (dmem_ready),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .id_ex_we     (id_ex_we),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mem_wb_flush (mem_wb_flush),
        .mem_err      (mem_err)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    task automatic drive(input logic [31:0] id, input logic [31:0] ex,
                         input logic [31:0] mem, input logic br,
                         input logic rdy);
        id_inst     = id;
        ex_inst     = ex;
        mem_inst    = mem;
        ex_br_taken = br;
        dmem_ready  = rdy;
    endtask

    task automatic chk_o(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, mem_wb_flush};
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: outputs got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_e(input string tag, input logic exp);
        nvec++;
        assert (mem_err === exp) else begin
            nerr++;
            $error("FAIL %s: mem_err got %b expected %b", tag, mem_err, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs at posedge+1, check at posedge+3, advance one cycle.
    task automatic step(input string tag, input logic [7:0] exp);
        #2;
        chk_o(tag, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        drive(NOP, NOP, NOP, 1'b0, 1'b1);
        #3;
        chk_o("reset_out", O_OFF);
        chk_e("reset_err", 1'b0);
`ifdef HAZ_PERF_CNT_EN
        chk_w("reset_stall", stall_cycles, 32'd0);
        chk_w("reset_flush", flush_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step("idle", O_ALL);

        drive(ADD1, LW5, NOP, 1'b0, 1'b1);
        step("lu_rs1", O_LU);
        drive(NOP, NOP, LW5, 1'b0, 1'b1);
        step("lu_one_cycle", O_ALL);
        drive(ADD2, LW5, NOP, 1'b0, 1'b1);
        step("lu_rs2", O_LU);
        drive(ADDI1, LW5, NOP, 1'b0, 1'b1);
        step("lu_itype_rs1", O_LU);
        drive(ADD1, LW0, NOP, 1'b0, 1'b1);
        step("no_lu_x0", O_ALL);
        drive(LUI, LW5, NOP, 1'b0, 1'b1);
        step("no_lu_lui", O_ALL);
        drive(ADDI5, LW5, NOP, 1'b0, 1'b1);
        step("no_lu_imm_rs2", O_ALL);

        drive(ADD1, LW5, NOP, 1'b1, 1'b1);
        step("br_over_lu", O_BR);
        drive(NOP, NOP, NOP, 1'b0, 1'b1);
        step("br_one_cycle", O_ALL);
`ifdef HAZ_PERF_CNT_EN
        chk_w("stall_after_lu", stall_cycles, 32'd3);
        chk_w("flush_after_br", flush_count, 32'd1);
`endif

        rstn = 1'b0;
        #1;
        chk_o("rst2_out", O_OFF);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        drive(NOP, NOP, LW5, 1'b0, 1'b0);
        step("mw_frz1", O_FRZ);
        step("mw_frz2", O_FRZ);
        step("mw_frz3", O_FRZ);
        drive(NOP, NOP, LW5, 1'b0, 1'b1);
        step("mw_release", O_ALL);
        drive(NOP, NOP, NOP, 1'b0, 1'b1);
        step("mw_after", O_ALL);
`ifdef HAZ_PERF_CNT_EN
        chk_w("stall_mw", stall_cycles, 32'd3);
`endif

        drive(NOP, NOP, LW5, 1'b1, 1'b0);
        step("brfrz_frz1", O_FRZ);
        step("brfrz_frz2", O_FRZ);
        drive(NOP, NOP, LW5, 1'b1, 1'b1);
        step("brfrz_release", O_BR);
        drive(NOP, NOP, NOP, 1'b0, 1'b1);
        step("brfrz_after", O_ALL);
        chk_e("no_err_yet", 1'b0);

        drive(NOP, NOP, LW5, 1'b0, 1'b0);
        step("to_frz1", O_FRZ);
        step("to_frz2", O_FRZ);
        step("to_frz3", O_FRZ);
        chk_e("to_err_pre", 1'b0);
        step("to_frz4", O_FRZ);
        chk_e("to_err_set", 1'b1);
        step("to_err_out", O_OFF);
        drive(NOP, NOP, NOP, 1'b0, 1'b1);
        step("to_err_hold", O_OFF);
        chk_e("to_err_sticky", 1'b1);

        rstn = 1'b0;
        #1;
        chk_o("rst3_out", O_OFF);
        chk_e("rst3_err", 1'b0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        step("rst3_run", O_ALL);

        drive(NOP, NOP, LW5, 1'b0, 1'b0);
        step("ar_frz1", O_FRZ);
        #2;
        chk_o("ar_frz2", O_FRZ);
        rstn = 1'b0;
        #1;
        chk_o("ar_async_off", O_OFF);
        #1;
        rstn = 1'b1;
        drive(NOP, NOP, NOP, 1'b0, 1'b0);
        #1;
        chk_o("ar_in_run", O_ALL);
        chk_e("ar_err", 1'b0);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

endmodule
